// File: rtl/rv32_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_bus_pkg : shared types and widths for the rv32 bus arbiter       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rv32_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/rv32_bus_fairness.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_bus_fairness : data-priority grant with bounded fetch starvation |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv32_bus_fairness #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic instr_req_i,
  input  logic data_req_i,
  input  logic grant_i,
  output logic grant_instr_o
);

  localparam logic [3:0] c_max_streak = MAX_DATA_STREAK[3:0];

  logic [3:0] streak_q;
  logic [3:0] streak_d;

  // Streak never exceeds the limit: reaching it forces the next grant to fetch.
  assign grant_instr_o = instr_req_i & (~data_req_i | (streak_q == c_max_streak));

  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if (grant_instr_o || !instr_req_i) begin
        streak_d = 4'd0;
      end else begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_bus_arbiter : shares one memory bus between fetch and data ports |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_read_in,
  input  logic [ADDR_W-1:0] instr_address_in,
  output logic              instr_ready_out,
  output logic [DATA_W-1:0] instr_read_value_out,
  input  logic              data_read_in,
  input  logic              data_write_in,
  input  logic [MASK_W-1:0] data_write_mask_in,
  input  logic [ADDR_W-1:0] data_address_in,
  input  logic [DATA_W-1:0] data_write_value_in,
  output logic              data_ready_out,
  output logic [DATA_W-1:0] data_read_value_out,
  output logic              bus_read_out,
  output logic [MASK_W-1:0] bus_write_mask_out,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic [DATA_W-1:0] bus_write_value_out,
  input  logic [DATA_W-1:0] bus_read_value_in,
  input  logic              bus_ack_in
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              bus_read_q, bus_read_d;
  logic [MASK_W-1:0] bus_mask_q, bus_mask_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              instr_ready_q, instr_ready_d;
  logic              data_ready_q, data_ready_d;

  logic w_data_req;
  logic w_arb;
  logic w_ack;
  logic w_grant_instr;

  assign w_data_req = data_read_in | data_write_in;
  assign w_arb      = (state_q == IDLE) & (instr_read_in | w_data_req);
  assign w_ack      = (state_q == BUSY) & bus_ack_in;

  rv32_bus_fairness #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_fairness (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_req_i  (instr_read_in),
    .data_req_i   (w_data_req),
    .grant_i      (w_arb),
    .grant_instr_o(w_grant_instr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_arb) state_d = BUSY;
      BUSY:    if (w_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d       = owner_q;
    bus_read_d    = bus_read_q;
    bus_mask_d    = bus_mask_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    instr_ready_d = 1'b0;
    data_ready_d  = 1'b0;
    if (w_arb) begin
      if (w_grant_instr) begin
        owner_d     = OWNER_INSTR;
        bus_read_d  = 1'b1;
        bus_mask_d  = '0;
        bus_addr_d  = instr_address_in;
        bus_wdata_d = '0;
      end else begin
        // A write takes precedence over a simultaneous read flag.
        owner_d     = OWNER_DATA;
        bus_read_d  = ~data_write_in;
        bus_mask_d  = data_write_in ? data_write_mask_in : '0;
        bus_addr_d  = data_address_in;
        bus_wdata_d = data_write_value_in;
      end
    end
    if (w_ack) begin
      if (owner_q == OWNER_INSTR) begin
        instr_ready_d = 1'b1;
        if (bus_read_q) instr_rdata_d = bus_read_value_in;
      end else begin
        data_ready_d = 1'b1;
        if (bus_read_q) data_rdata_d = bus_read_value_in;
      end
      bus_read_d  = 1'b0;
      bus_mask_d  = '0;
      bus_addr_d  = '0;
      bus_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q       <= OWNER_INSTR;
      bus_read_q    <= 1'b0;
      bus_mask_q    <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      bus_read_q    <= bus_read_d;
      bus_mask_q    <= bus_mask_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
      instr_ready_q <= instr_ready_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign instr_ready_out      = instr_ready_q;
  assign instr_read_value_out = instr_rdata_q;
  assign data_ready_out       = data_ready_q;
  assign data_read_value_out  = data_rdata_q;
  assign bus_read_out         = bus_read_q;
  assign bus_write_mask_out   = bus_mask_q;
  assign bus_address_out      = bus_addr_q;
  assign bus_write_value_out  = bus_wdata_q;

endmodule
`default_nettype wire

// File: doc/rv32_bus_arbiter.md
# rv32_bus_arbiter

Shares one external memory bus between the instruction-fetch port and the data (mem-stage) port of the rv32 core. Requests are arbitrated with fixed data priority and a bounded-starvation rule for fetch. Each granted access is driven onto the bus until the bus acknowledges it. The winning port then receives its read data and a one-cycle ready pulse, and its pipeline stage stalls until that pulse arrives.

## Interface
- MAX_DATA_STREAK, default 4: consecutive data grants allowed while fetch waits; range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_read_in  in  1  fetch requests a read; held until instr_ready_out.
- instr_address_in  in  32  fetch address; stable while requesting.
- instr_ready_out  out  1  one-cycle pulse; fetch access complete.
- instr_read_value_out  out  32  fetched word; held until the next fetch completion.
- data_read_in  in  1  data load request; held until data_ready_out.
- data_write_in  in  1  data store request; held until data_ready_out.
- data_write_mask_in  in  4  byte enables for stores.
- data_address_in  in  32  data address.
- data_write_value_in  in  32  store data.
- data_ready_out  out  1  one-cycle pulse; data access complete.
- data_read_value_out  out  32  load result; held until the next data completion.
- bus_read_out  out  1  bus read strobe.
- bus_write_mask_out  out  4  bus byte-write enables; 0 for reads.
- bus_address_out  out  32  bus address.
- bus_write_value_out  out  32  bus store data.
- bus_read_value_in  in  32  bus read data; valid when bus_ack_in=1.
- bus_ack_in  in  1  bus completes the current access.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with no request: stay in IDLE; all bus outputs are 0.
- IDLE with any request:
  - Select the winner.
  - Register the winner's address, read/mask and write value into the bus registers.
  - Record the owner (INSTR or DATA) and move to BUSY.
- Winner selection:
  - Data wins by default.
  - Fetch wins if fetch is the only requester.
  - Fetch also wins if both request and streak == MAX_DATA_STREAK.
- Data request decode:
  - A data request is data_read_in or data_write_in.
  - A write yields bus_write_mask_out = data_write_mask_in and bus_read_out = 0.
  - A read yields bus_read_out = 1 and mask 0.
  - data_read_in and data_write_in both set: the write is issued and the read flag is ignored.
  - A write with mask 0 is still issued to the bus.
- A fetch grant always yields bus_read_out = 1 and mask 0.
- Streak counter (4 bits):
  - Data grant while instr_read_in=1: streak increments.
  - Data grant while instr_read_in=0: streak clears.
  - Fetch grant: streak clears.
- BUSY:
  - Bus outputs are held stable.
  - When bus_ack_in=1: capture bus_read_value_in into the owner's read_value_out (read accesses only), clear the bus outputs to 0, and move to DONE.
- DONE:
  - The owner's ready_out is 1 for exactly this cycle.
  - No arbitration happens in DONE.
  - Next state is IDLE.
- Requests that change or drop while BUSY are ignored. The registered copy is authoritative.
- Reset, including mid-transaction:
  - State goes to IDLE and streak to 0.
  - All outputs go to 0, including both read_value_out.
  - The in-flight bus access is abandoned; the bus shares reset_n.

## Timing
- Request first seen in IDLE at edge N: bus outputs are valid from N+1.
- bus_ack_in sampled at edge M (M ≥ N+1): ready pulse and read value are valid in cycle M+1.
- Minimum access is 3 cycles from request to ready (ack on the first BUSY cycle).
- After the ready pulse, re-arbitration occurs in the following IDLE cycle.
- A requester samples ready and updates or drops its request at that same edge.
- Back-to-back accesses from one port therefore cost 3 cycles each, minimum.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package rv32_bus_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - owner enum {OWNER_INSTR, OWNER_DATA};
  - widths ADDR_W=32 and MASK_W=4.
- Sub-module rv32_bus_fairness holds the streak counter and the grant decision:
  - inputs: instr/data request and a grant strobe;
  - output: grant_instr.
- The top level holds the FSM, the bus registers and the per-port read-value registers.

## Test plan
- Lone fetch of 0x100, ack 2 cycles after the bus read is driven: bus_read_out=1, bus_address_out=0x100 from N+1; instr_ready_out pulses once; instr_read_value_out = ack data 0xDEADBEEF; data port untouched.
- Store to 0x2000, mask 4'b0011, value 0x1234ABCD, immediate ack: bus_write_mask_out=0011 and bus_read_out=0 for one cycle; data_ready_out pulses; data_read_value_out stays unchanged.
- Fetch and data requesting continuously, MAX_DATA_STREAK=4, single-cycle ack: grant order D,D,D,D,I,D,D,D,D,I,…; no overlapping ready pulses.
- Requests change while BUSY (address 0x40 → 0x80): bus_address_out stays 0x40 until ack.
- reset_n deasserted during BUSY: all outputs 0 immediately (asynchronously); after release, the first pending request is granted fresh with streak=0.
- bus_ack_in held low for 50 cycles: bus outputs stay stable and no ready pulse occurs until the ack.
